// File: rtl/csr_machine_unit_rv32.sv
// Machine-mode CSR unit for RV32: operand formation, CSRRW/RS/RC read-modify-write,
// WARL handling for misa/mtvec/mepc, trap capture and 64-bit mcycle/minstret counters.
module csr_machine_unit_rv32 #(
    parameter logic [1:0]  MXL         = 2'b01,
    parameter logic [25:0] MISA_EXT    = 26'h0000100,
    parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
    parameter bit          VECTORED_EN = 1'b1,
    parameter bit          CNT_EN      = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        csr_en_in,
    input  logic [2:0]  csr_op_in,
    input  logic [11:0] csr_addr_in,
    input  logic [4:0]  csr_uimm_in,
    input  logic [31:0] csr_data_in,
    input  logic        instret_inc_in,
    input  logic        trap_taken_in,
    input  logic [31:0] trap_cause_in,
    input  logic [31:0] trap_pc_in,
    output logic [31:0] csr_rdata_out,
    output logic        csr_illegal_out,
    output logic [31:0] misa_out,
    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out
);
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    localparam logic [31:0] MISA_VAL = {MXL, 4'b0000, MISA_EXT};
    // Reset mode falls back to direct (00) when the parameter asks for an unsupported mode.
    localparam logic [1:0]  MTVEC_RST_MODE =
        ((MTVEC_RST[1:0] == 2'b00) || ((MTVEC_RST[1:0] == 2'b01) && VECTORED_EN)) ?
        MTVEC_RST[1:0] : 2'b00;

    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;

    logic        w_known;
    logic [31:0] w_old;
    logic [31:0] w_operand;
    logic [31:0] w_new;
    logic        w_wr_req;
    logic        w_illegal;
    logic        w_we;
    logic [1:0]  w_mtvec_mode;
    logic [63:0] w_mcycle_inc;
    logic [63:0] w_minstret_inc;
    logic [63:0] w_mcycle_d;
    logic [63:0] w_minstret_d;

    always_comb begin
        w_known = 1'b1;
        w_old   = 32'h0;
        case (csr_addr_in)
            ADDR_MISA:      w_old = MISA_VAL;
            ADDR_MTVEC:     w_old = r_mtvec;
            ADDR_MSCRATCH:  w_old = r_mscratch;
            ADDR_MEPC:      w_old = r_mepc;
            ADDR_MCAUSE:    w_old = r_mcause;
            ADDR_MCYCLE:    w_old = CNT_EN ? r_mcycle[31:0] : 32'h0;
            ADDR_MINSTRET:  w_old = CNT_EN ? r_minstret[31:0] : 32'h0;
            ADDR_MCYCLEH:   w_old = CNT_EN ? r_mcycle[63:32] : 32'h0;
            ADDR_MINSTRETH: w_old = CNT_EN ? r_minstret[63:32] : 32'h0;
            ADDR_MHARTID:   w_old = 32'h0;
            default:        w_known = 1'b0;
        endcase
    end

    always_comb begin
        w_operand = csr_op_in[2] ? {27'b0, csr_uimm_in} : csr_data_in;
        case (csr_op_in[1:0])
            2'b01:   w_new = w_operand;
            2'b10:   w_new = w_old | w_operand;
            2'b11:   w_new = w_old & ~w_operand;
            default: w_new = w_old;
        endcase
        // Set/clear forms with a zero rs1/uimm field are pure reads.
        w_wr_req  = (csr_op_in[1:0] == 2'b01) || (csr_uimm_in != 5'd0);
        w_illegal = csr_en_in && (!w_known || (csr_op_in[1:0] == 2'b00) ||
                                  ((csr_addr_in[11:10] == 2'b11) && w_wr_req));
        w_we      = csr_en_in && w_wr_req && !w_illegal && !trap_taken_in;
        w_mtvec_mode = ((w_new[1:0] == 2'b00) || ((w_new[1:0] == 2'b01) && VECTORED_EN)) ?
                       w_new[1:0] : r_mtvec[1:0];
    end

    always_comb begin
        w_mcycle_inc   = r_mcycle + 64'd1;
        w_minstret_inc = r_minstret + {63'd0, instret_inc_in};
        w_mcycle_d     = w_mcycle_inc;
        w_minstret_d   = w_minstret_inc;
        // A written half takes the new value; the other half neither gains nor loses a carry.
        if (w_we && (csr_addr_in == ADDR_MCYCLE)) begin
            w_mcycle_d = {r_mcycle[63:32], w_new};
        end else if (w_we && (csr_addr_in == ADDR_MCYCLEH)) begin
            w_mcycle_d = {w_new, w_mcycle_inc[31:0]};
        end
        if (w_we && (csr_addr_in == ADDR_MINSTRET)) begin
            w_minstret_d = {r_minstret[63:32], w_new};
        end else if (w_we && (csr_addr_in == ADDR_MINSTRETH)) begin
            w_minstret_d = {w_new, w_minstret_inc[31:0]};
        end
        if (!CNT_EN) begin
            w_mcycle_d   = 64'd0;
            w_minstret_d = 64'd0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_mtvec    <= {MTVEC_RST[31:2], MTVEC_RST_MODE};
            r_mscratch <= 32'h0;
            r_mepc     <= 32'h0;
            r_mcause   <= 32'h0;
            r_mcycle   <= 64'd0;
            r_minstret <= 64'd0;
        end else begin
            r_mcycle   <= w_mcycle_d;
            r_minstret <= w_minstret_d;
            if (trap_taken_in) begin
                r_mepc   <= trap_pc_in & 32'hFFFF_FFFC;
                r_mcause <= trap_cause_in;
            end else if (w_we) begin
                case (csr_addr_in)
                    ADDR_MTVEC:    r_mtvec    <= {w_new[31:2], w_mtvec_mode};
                    ADDR_MSCRATCH: r_mscratch <= w_new;
                    ADDR_MEPC:     r_mepc     <= {w_new[31:2], 2'b00};
                    ADDR_MCAUSE:   r_mcause   <= w_new;
                    default:       ;
                endcase
            end
        end
    end

    assign csr_illegal_out = rst_n_in && w_illegal;
    assign csr_rdata_out   = (rst_n_in && csr_en_in && !w_illegal) ? w_old : 32'h0;
    assign misa_out        = MISA_VAL;
    assign mtvec_out       = r_mtvec;
    assign mepc_out        = r_mepc;

endmodule

// File: tb/tb_csr_machine_unit_rv32.sv
// Scoreboard bench for csr_machine_unit_rv32: driver pushes model expectations,
// a negedge monitor pops and compares whenever a CSR access is presented.
`timescale 1ns/1ps
module tb_csr_machine_unit_rv32;
    localparam logic [1:0]  MXL       = 2'b01;
    localparam logic [25:0] MISA_EXT  = 26'h0000100;
    localparam logic [31:0] MTVEC_RST = 32'h8000_0001;
    localparam bit          VEC       = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        csr_en = 1'b0;
    logic [2:0]  csr_op = 3'b000;
    logic [11:0] csr_addr = 12'h0;
    logic [4:0]  csr_uimm = 5'd0;
    logic [31:0] csr_data = 32'h0;
    logic        instret_inc = 1'b0;
    logic        trap_taken = 1'b0;
    logic [31:0] trap_cause = 32'h0;
    logic [31:0] trap_pc = 32'h0;
    logic [31:0] rdata;
    logic        illegal;
    logic [31:0] misa;
    logic [31:0] mtvec;
    logic [31:0] mepc;

    csr_machine_unit_rv32 #(
        .MXL(MXL), .MISA_EXT(MISA_EXT), .MTVEC_RST(MTVEC_RST),
        .VECTORED_EN(VEC), .CNT_EN(1'b1)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n), .csr_en_in(csr_en), .csr_op_in(csr_op),
        .csr_addr_in(csr_addr), .csr_uimm_in(csr_uimm), .csr_data_in(csr_data),
        .instret_inc_in(instret_inc), .trap_taken_in(trap_taken),
        .trap_cause_in(trap_cause), .trap_pc_in(trap_pc), .csr_rdata_out(rdata),
        .csr_illegal_out(illegal), .misa_out(misa), .mtvec_out(mtvec), .mepc_out(mepc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        illegal;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    // Reference state
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_cycle, m_instret;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic bit mode_ok(input logic [1:0] m);
        return (m == 2'b00) || (m == 2'b01 && VEC);
    endfunction

    task automatic model_reset();
        logic [31:0] r;
        r = MTVEC_RST;
        m_mtvec    = {r[31:2], mode_ok(r[1:0]) ? r[1:0] : 2'b00};
        m_mscratch = 0;
        m_mepc     = 0;
        m_mcause   = 0;
        m_cycle    = 0;
        m_instret  = 0;
    endtask

    function automatic bit known(input logic [11:0] a);
        return a inside {12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
                         12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF14};
    endfunction

    function automatic logic [31:0] read_val(input logic [11:0] a);
        case (a)
            12'h301: return {MXL, 4'b0000, MISA_EXT};
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hB00: return m_cycle[31:0];
            12'hB02: return m_instret[31:0];
            12'hB80: return m_cycle[63:32];
            12'hB82: return m_instret[63:32];
            default: return 32'h0;
        endcase
    endfunction

    task automatic do_cycle(input logic en, input logic [2:0] op, input logic [11:0] addr,
                            input logic [4:0] uimm, input logic [31:0] data, input logic inst,
                            input logic trap, input logic [31:0] cause,
                            input logic [31:0] pc, input string name);
        exp_t        e;
        logic        wr, ill;
        logic [31:0] old, opnd, nv;
        logic [63:0] nc, ni;
        csr_en = en; csr_op = op; csr_addr = addr; csr_uimm = uimm; csr_data = data;
        instret_inc = inst; trap_taken = trap; trap_cause = cause; trap_pc = pc;
        wr  = (op[1:0] == 2'b01) || (uimm != 0);
        ill = en && (!known(addr) || op[1:0] == 2'b00 || (addr[11:10] == 2'b11 && wr));
        old = read_val(addr);
        if (en) begin
            e.rdata = ill ? 32'h0 : old;
            e.illegal = ill;
            e.mtvec = m_mtvec;
            e.mepc = m_mepc;
            e.name = name;
            q.push_back(e);
        end
        opnd = op[2] ? {27'b0, uimm} : data;
        case (op[1:0])
            2'b01:   nv = opnd;
            2'b10:   nv = old | opnd;
            2'b11:   nv = old & ~opnd;
            default: nv = old;
        endcase
        nc = m_cycle + 1;
        ni = m_instret + {63'd0, inst};
        if (trap) begin
            m_mepc   = {pc[31:2], 2'b00};
            m_mcause = cause;
        end else if (en && wr && !ill) begin
            case (addr)
                12'h305: m_mtvec = {nv[31:2], mode_ok(nv[1:0]) ? nv[1:0] : m_mtvec[1:0]};
                12'h340: m_mscratch = nv;
                12'h341: m_mepc = {nv[31:2], 2'b00};
                12'h342: m_mcause = nv;
                12'hB00: nc = {m_cycle[63:32], nv};
                12'hB02: ni = {m_instret[63:32], nv};
                12'hB80: nc[63:32] = nv;
                12'hB82: ni[63:32] = nv;
                default: ;
            endcase
        end
        m_cycle = nc;
        m_instret = ni;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] addr, input string name);
        do_cycle(1'b1, 3'b010, addr, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 0, name);
    endtask

    task automatic wr_csr(input logic [2:0] op, input logic [11:0] addr, input logic [4:0] uimm,
                          input logic [31:0] data, input string name);
        do_cycle(1'b1, op, addr, uimm, data, 1'b0, 1'b0, 0, 0, name);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && csr_en) begin
            if (q.size() == 0) begin
                check("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check({e.name, "_rdata"}, rdata, e.rdata);
                check({e.name, "_illegal"}, {31'b0, illegal}, {31'b0, e.illegal});
                check({e.name, "_mtvec"}, mtvec, e.mtvec);
                check({e.name, "_mepc"}, mepc, e.mepc);
                check({e.name, "_misa"}, misa, 32'h4000_0100);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] addrs [12];
        logic [11:0] a;
        addrs = '{12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB02,
                  12'hB80, 12'hB82, 12'hF14, 12'h7C0, 12'h000};
        model_reset();
        csr_en = 1'b1; csr_op = 3'b001; csr_addr = 12'h340; csr_data = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #2;
        check("rst_mtvec", mtvec, 32'h8000_0000);
        check("rst_misa", misa, 32'h4000_0100);
        check("rst_rdata", rdata, 32'h0);
        check("rst_illegal", {31'b0, illegal}, 32'h0);
        check("rst_mepc", mepc, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        rd(12'hB00, "mcycle_first");
        wr_csr(3'b001, 12'h340, 5'd1, 32'hDEAD_BEEF, "rw_mscratch");
        wr_csr(3'b010, 12'h340, 5'd1, 32'h0000_0010, "rs_mscratch");
        wr_csr(3'b111, 12'h340, 5'h1F, 32'h0, "rci_mscratch");
        rd(12'h340, "rd_mscratch");
        wr_csr(3'b010, 12'h341, 5'd0, 32'h0000_FFFF, "rs_mepc_nowrite");
        rd(12'h341, "rd_mepc");
        wr_csr(3'b001, 12'hF14, 5'd0, 32'h1, "rw_mhartid");
        rd(12'hF14, "rd_mhartid");
        wr_csr(3'b001, 12'h7C0, 5'd0, 32'h1, "rw_unknown");
        wr_csr(3'b000, 12'h340, 5'd1, 32'h1, "op000");
        wr_csr(3'b100, 12'h340, 5'd1, 32'h1, "op100");
        wr_csr(3'b001, 12'h305, 5'd1, 32'h1235_6781, "mtvec_vec");
        wr_csr(3'b001, 12'h305, 5'd1, 32'h0000_0102, "mtvec_mode2");
        wr_csr(3'b001, 12'h301, 5'd1, 32'h0, "misa_write");
        rd(12'h301, "rd_misa");
        wr_csr(3'b001, 12'hB80, 5'd1, 32'h0, "wr_mcycleh");
        wr_csr(3'b001, 12'hB00, 5'd1, 32'hFFFF_FFFF, "wr_mcycle");
        do_cycle(1'b0, 3'b000, 12'h0, 5'd0, 0, 1'b0, 1'b0, 0, 0, "idle");
        rd(12'hB80, "rd_mcycleh_carry");
        rd(12'hB00, "rd_mcycle_wrap");
        do_cycle(1'b1, 3'b001, 12'hB02, 5'd1, 32'h100, 1'b1, 1'b0, 0, 0, "wr_minstret");
        rd(12'hB02, "rd_minstret_held");
        do_cycle(1'b1, 3'b001, 12'h341, 5'd1, 32'hAAAA_AAAA, 1'b1, 1'b1, 32'hB,
                 32'h0000_1236, "trap_rw");
        rd(12'h341, "rd_mepc_trap");
        rd(12'h342, "rd_mcause_trap");

        for (int i = 0; i < 400; i++) begin
            a = addrs[$urandom_range(0, 11)];
            if (a == 12'h000) a = 12'($urandom);
            do_cycle(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), a,
                     ($urandom_range(0, 1) != 0) ? 5'($urandom) : 5'd0, $urandom,
                     1'($urandom), ($urandom_range(0, 15) == 0), $urandom, $urandom,
                     "random");
        end

        // Asynchronous reset pulse between edges while a write is being presented.
        csr_en = 1'b1; csr_op = 3'b001; csr_addr = 12'h340; csr_uimm = 5'd1;
        csr_data = 32'h5555_AAAA; trap_taken = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_rdata", rdata, 32'h0);
        check("midrst_illegal", {31'b0, illegal}, 32'h0);
        check("midrst_mepc", mepc, 32'h0);
        rst_n = 1'b1;
        model_reset();
        rd(12'hB00, "postrst_mcycle");
        rd(12'hB82, "postrst_minstreth");
        rd(12'h340, "postrst_mscratch");
        rd(12'h305, "postrst_mtvec");
        csr_en = 1'b0;
        #1;
        check("queue_drain", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
